// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Instruction fetch queue between the PC and decode. Each cycle the current
//   fetch address is issued to instruction memory (split address/data
//   handshake) and an in-order slot is reserved for it. Misaligned addresses
//   get a pre-filled address-error slot and no memory request. Entries
//   {pc, inst, adel} are handed to decode over valid/ready. A redirect
//   (flush_i) empties the queue and counts the still-outstanding responses
//   so they can be discarded when they return.
//
//   Optional feature macro: IFETCH_BYPASS_EN -- when defined, read data that
//   fills the head slot is presented to decode combinationally in the same
//   cycle.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   pc_address         current fetch address (already redirected)
//   alignment_error    pc_address[1:0] != 0
//   flush_i            redirect this cycle
//   stall_o            1 = pc_address not consumed this cycle
//   inst_req/inst_addr memory request valid / address
//   inst_addr_ok       memory accepted the request
//   inst_data_ok       in-order read data returned, inst_rdata valid
//   out_valid/out_ready decode handshake
//   out_pc/out_inst/out_adel head entry contents
module ifetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_address,
    input  logic        alignment_error,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adel
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0]      slot_pc   [DEPTH];
    logic [31:0]      slot_inst [DEPTH];
    logic [DEPTH-1:0] slot_adel;
    logic [DEPTH-1:0] slot_filled;

    ptr_t head_ptr;
    ptr_t alloc_ptr;
    cnt_t count;
    cnt_t drop_cnt;

    ptr_t fill_ptr;
    logic fill_found;
    cnt_t pend;
    cnt_t drop_flush;
    logic space;
    logic alloc;
    ptr_t alloc_idx;
    logic fill_en;
    logic pop;
    logic byp_pop;

    // The oldest unfilled occupied slot is the fill target; misaligned slots
    // are born filled, so they are skipped naturally. The same scan counts
    // the outstanding aligned fetches needed when a flush drops them.
    always_comb begin
        pend       = '0;
        fill_found = 1'b0;
        fill_ptr   = head_ptr;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if ((CW'(k) < count) && !slot_filled[head_ptr + PW'(k)]) begin
                pend       = pend + cnt_t'(1);
                fill_found = 1'b1;
                fill_ptr   = head_ptr + PW'(k);
            end
        end
    end

    // On a flush the returning beat (if any) retires one of the old pending
    // fetches, whichever bucket it was headed for.
    assign drop_flush = drop_cnt + pend - cnt_t'(inst_data_ok);

    // An allocation in the flush cycle sees the post-flush queue (empty)
    // but must still leave room for every response that will be dropped.
    assign space = rst_n && (flush_i ? (drop_flush < cnt_t'(DEPTH))
                                     : ((count + drop_cnt) < cnt_t'(DEPTH)));

    assign inst_req  = space && !alignment_error;
    assign inst_addr = pc_address;
    assign alloc     = space && (alignment_error || inst_addr_ok);
    assign stall_o   = !alloc;
    assign alloc_idx = flush_i ? '0 : alloc_ptr;

    assign fill_en = inst_data_ok && (drop_cnt == '0) && fill_found && !flush_i;

    assign out_pc   = slot_pc[head_ptr];
    assign out_adel = slot_adel[head_ptr];

`ifdef IFETCH_BYPASS_EN
    logic byp;
    assign byp       = fill_en && (fill_ptr == head_ptr);
    assign out_valid = !flush_i && (count != '0) && (slot_filled[head_ptr] || byp);
    assign out_inst  = byp ? inst_rdata : slot_inst[head_ptr];
    assign byp_pop   = byp && out_ready;
`else
    assign out_valid = !flush_i && (count != '0) && slot_filled[head_ptr];
    assign out_inst  = slot_inst[head_ptr];
    assign byp_pop   = 1'b0;
`endif

    assign pop = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr    <= '0;
            alloc_ptr   <= '0;
            count       <= '0;
            drop_cnt    <= '0;
            slot_filled <= '0;
            slot_adel   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc[i]   <= '0;
                slot_inst[i] <= '0;
            end
        end else begin
            if (flush_i) begin
                head_ptr    <= '0;
                alloc_ptr   <= alloc ? ptr_t'(1) : '0;
                count       <= alloc ? cnt_t'(1) : '0;
                drop_cnt    <= drop_flush;
                slot_filled <= '0;
            end else begin
                head_ptr  <= head_ptr + ptr_t'(pop);
                alloc_ptr <= alloc_ptr + ptr_t'(alloc);
                count     <= count + cnt_t'(alloc) - cnt_t'(pop);
                if (inst_data_ok && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - cnt_t'(1);
                if (fill_en) begin
                    slot_inst[fill_ptr] <= inst_rdata;
                    // A bypassed entry retires this cycle; its slot stays free.
                    if (!byp_pop)
                        slot_filled[fill_ptr] <= 1'b1;
                end
            end
            // Allocation never targets the slot being filled or popped.
            if (alloc) begin
                slot_pc[alloc_idx]     <= pc_address;
                slot_inst[alloc_idx]   <= '0;
                slot_adel[alloc_idx]   <= alignment_error;
                slot_filled[alloc_idx] <= alignment_error;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: directed cycles with a queue-based reference
// model plus hand-computed literal expectations.
module tb_ifetch_queue;

    localparam int DEPTH = 4;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_address;
    logic        alignment_error;
    logic        flush_i;
    logic        stall_o;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_address(pc_address), .alignment_error(alignment_error),
        .flush_i(flush_i), .stall_o(stall_o),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_adel(out_adel)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
        logic        filled;
    } ent_t;

    ent_t q[$];
    int   drop = 0;
    int   checks = 0;
    int   failures = 0;

    logic        s_ov, s_adel, s_stall, s_req;
    logic [31:0] s_pc, s_inst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model.
    task automatic cyc(input logic [31:0] pc, input logic fl, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic rdy);
        int          pend;
        int          dropn;
        bit          space, alloc, ov, ae, done;
        logic [31:0] einst;
        @(negedge clk);
        pc_address      = pc;
        alignment_error = (pc[1:0] != 2'b00);
        flush_i         = fl;
        inst_addr_ok    = aok;
        inst_data_ok    = dok;
        inst_rdata      = rd;
        out_ready       = rdy;
        #1;
        ae   = (pc[1:0] != 2'b00);
        pend = 0;
        foreach (q[i]) if (!q[i].filled) pend++;
        if (fl) dropn = drop + pend - (dok ? 1 : 0);
        else    dropn = drop - ((dok && drop > 0) ? 1 : 0);
        space = fl ? (dropn < DEPTH) : (q.size() + drop < DEPTH);
        alloc = space && (ae || aok);
        ov    = !fl && q.size() > 0 && q[0].filled;
        einst = ov ? q[0].inst : 32'h0;
        if (BYP && !fl && dok && drop == 0 && q.size() > 0 && !q[0].filled) begin
            ov    = 1'b1;
            einst = rd;
        end

        s_ov = out_valid; s_pc = out_pc; s_inst = out_inst; s_adel = out_adel;
        s_stall = stall_o; s_req = inst_req;

        chk("stall_o", {31'b0, stall_o}, {31'b0, !alloc});
        chk("inst_req", {31'b0, inst_req}, {31'b0, space && !ae});
        if (inst_req) chk("inst_addr", inst_addr, pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, ov});
        if (ov) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_inst", out_inst, einst);
            chk("out_adel", {31'b0, out_adel}, {31'b0, q[0].adel});
        end

        if (fl) begin
            q.delete();
            drop = dropn;
        end else begin
            if (dok) begin
                if (drop > 0) drop--;
                else begin
                    done = 1'b0;
                    foreach (q[i]) if (!done && !q[i].filled) begin
                        q[i].inst = rd; q[i].filled = 1'b1; done = 1'b1;
                    end
                end
            end
            if (ov && rdy) void'(q.pop_front());
        end
        if (alloc) q.push_back('{pc: pc, inst: 32'h0, adel: ae, filled: ae});
    endtask

    initial begin
        rst_n = 1'b0;
        pc_address = 32'h0; alignment_error = 1'b0; flush_i = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        out_ready = 1'b0;
        #12;
        chk("rst out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst out_pc", out_pc, 32'h0);
        chk("rst out_inst", out_inst, 32'h0);
        chk("rst out_adel", {31'b0, out_adel}, 32'h0);
        chk("rst inst_req", {31'b0, inst_req}, 32'h0);
        chk("rst stall_o", {31'b0, stall_o}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single aligned fetch, data one cycle after accept.
        cyc(32'hbfc00000, 0, 1, 0, 32'h0, 1);
        chk("s1 req", {31'b0, s_req}, 32'h1);
        chk("s1 stall", {31'b0, s_stall}, 32'h0);
        cyc(32'hbfc00004, 0, 0, 1, 32'h24080001, 1);
        chk("s1 ov data cycle", {31'b0, s_ov}, {31'b0, BYP});
        if (s_ov) chk("s1 inst byp", s_inst, 32'h24080001);
        cyc(32'hbfc00004, 0, 0, 0, 32'h0, 1);
        chk("s1 ov accept+2", {31'b0, s_ov}, {31'b0, !BYP});
        if (s_ov) begin
            chk("s1 pc", s_pc, 32'hbfc00000);
            chk("s1 inst", s_inst, 32'h24080001);
            chk("s1 adel", {31'b0, s_adel}, 32'h0);
        end

        // Fill to DEPTH with decode stalled, then one pop frees one slot.
        for (int i = 0; i < 5; i++) begin
            cyc(32'h1000 + 32'(4 * i), 0, 1, 0, 32'h0, 0);
            if (i == 3) chk("s2 4th alloc", {31'b0, s_stall}, 32'h0);
        end
        chk("s2 full stall", {31'b0, s_stall}, 32'h1);
        chk("s2 full req", {31'b0, s_req}, 32'h0);
        for (int i = 0; i < 4; i++) cyc(32'h1010, 0, 1, 1, 32'ha0 + 32'(i), 0);
        cyc(32'h1010, 0, 1, 0, 32'h0, 1);
        chk("s2 pop pc", s_pc, 32'h1000);
        chk("s2 pop inst", s_inst, 32'ha0);
        chk("s2 pop cycle stall", {31'b0, s_stall}, 32'h1);
        cyc(32'h1010, 0, 1, 0, 32'h0, 0);
        chk("s2 alloc after pop", {31'b0, s_stall}, 32'h0);
        cyc(32'h1014, 0, 0, 1, 32'hb4, 1);
        for (int i = 0; i < 3; i++) cyc(32'h1014, 0, 0, 0, 32'h0, 1);
        chk("s2 last pc", s_pc, 32'h1010);
        chk("s2 last inst", s_inst, 32'hb4);

        // Misaligned entry behind a pending aligned fetch.
        cyc(32'hbfc00010, 0, 1, 0, 32'h0, 1);
        cyc(32'hbfc00002, 0, 0, 0, 32'h0, 1);
        chk("s3 mis req", {31'b0, s_req}, 32'h0);
        chk("s3 mis stall", {31'b0, s_stall}, 32'h0);
        chk("s3 mis not head", {31'b0, s_ov}, 32'h0);
        cyc(32'hbfc00004, 0, 0, 1, 32'h11223344, 0);
        cyc(32'hbfc00004, 0, 0, 0, 32'h0, 1);
        chk("s3 first pc", s_pc, 32'hbfc00010);
        chk("s3 first inst", s_inst, 32'h11223344);
        cyc(32'hbfc00004, 0, 0, 0, 32'h0, 1);
        chk("s3 mis ov", {31'b0, s_ov}, 32'h1);
        chk("s3 mis pc", s_pc, 32'hbfc00002);
        chk("s3 mis inst", s_inst, 32'h0);
        chk("s3 mis adel", {31'b0, s_adel}, 32'h1);

        // Flush with two fetches outstanding, new target accepted same cycle.
        cyc(32'h100, 0, 1, 0, 32'h0, 0);
        cyc(32'h104, 0, 1, 0, 32'h0, 0);
        cyc(32'hbfc00380, 1, 1, 0, 32'h0, 0);
        chk("s4 flush alloc", {31'b0, s_stall}, 32'h0);
        cyc(32'hbfc00384, 0, 0, 1, 32'hdead0001, 0);
        cyc(32'hbfc00384, 0, 0, 1, 32'hdead0002, 0);
        chk("s4 dropped", {31'b0, s_ov}, 32'h0);
        cyc(32'hbfc00384, 0, 0, 1, 32'h11112222, 0);
        cyc(32'hbfc00384, 0, 0, 0, 32'h0, 1);
        chk("s4 ov", {31'b0, s_ov}, 32'h1);
        chk("s4 pc", s_pc, 32'hbfc00380);
        chk("s4 inst", s_inst, 32'h11112222);

        // Flush coinciding with data_ok and a would-be pop.
        cyc(32'h200, 0, 1, 0, 32'h0, 0);
        cyc(32'h204, 0, 1, 1, 32'h0a0a0a0a, 0);
        cyc(32'h208, 0, 1, 0, 32'h0, 0);
        cyc(32'h300, 1, 0, 1, 32'hdead0003, 1);
        chk("s5 flush ov", {31'b0, s_ov}, 32'h0);
        chk("s5 flush stall", {31'b0, s_stall}, 32'h1);
        cyc(32'h300, 0, 1, 1, 32'hdead0004, 0);
        cyc(32'h304, 0, 0, 1, 32'h00000055, 0);
        cyc(32'h304, 0, 0, 0, 32'h0, 1);
        chk("s5 ov", {31'b0, s_ov}, 32'h1);
        chk("s5 pc", s_pc, 32'h300);
        chk("s5 inst", s_inst, 32'h55);

        // Data into an empty-but-allocated head: bypass timing.
        cyc(32'h400, 0, 1, 0, 32'h0, 1);
        cyc(32'h404, 0, 0, 1, 32'h77, 1);
        chk("s6 ov same cycle", {31'b0, s_ov}, {31'b0, BYP});
        cyc(32'h404, 0, 0, 0, 32'h0, 1);
        chk("s6 ov next cycle", {31'b0, s_ov}, {31'b0, !BYP});
        if (s_ov) chk("s6 inst", s_inst, 32'h77);
        cyc(32'h404, 0, 0, 0, 32'h0, 1);
        chk("s6 empty", {31'b0, s_ov}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue sitting directly downstream of the program counter. Each cycle it takes the current fetch address and issues it to instruction memory over an address/data split handshake. It reserves an in-order slot per fetch and delivers {pc, instruction, address-error} entries to decode over a valid/ready interface. It drives the PC's stall input whenever the current address cannot be accepted, and discards in-flight responses on a redirect.

## Interface
- DEPTH, 4: queue slots; power of two, ≥2; also the bound on allocated plus dropped-pending fetches.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_address  in  32  current fetch address from the PC; combinational, already redirected on branch/exception.
- alignment_error  in  1  pc_address[1:0] != 0.
- flush_i  in  1  redirect this cycle (branch or exception taken); pc_address already carries the new target.
- stall_o  out  1  to PC stall input; 1 = current pc_address not consumed this cycle.
- inst_req  out  1  memory request valid.
- inst_addr  out  32  request address; equals pc_address.
- inst_addr_ok  in  1  memory accepted the request this cycle.
- inst_data_ok  in  1  in-order read data returned this cycle.
- inst_rdata  in  32  read data; valid with inst_data_ok.
- out_valid  out  1  head entry ready for decode.
- out_ready  in  1  decode consumes head.
- out_pc  out  32  head entry address.
- out_inst  out  32  head entry instruction; 0 for misaligned entries.
- out_adel  out  1  head entry is an address-error fetch.

## Operation
- Circular buffer of DEPTH entries {pc, inst, adel, filled}, with alloc, fill and head pointers and count. Each pointer has log2(DEPTH) bits and wraps modulo DEPTH.
- Space condition: count + drop_cnt < DEPTH, using registered values. A pop in the same cycle does not free space for that cycle.
- Aligned fetch: inst_req = space && !alignment_error. On inst_req && inst_addr_ok, allocate a slot {pc_address, filled=0} and advance alloc.
- Misaligned fetch: no memory request. If space, allocate a slot {pc_address, inst=0, adel=1, filled=1}. Order is preserved by the slot.
- stall_o = !(allocation this cycle).
- inst_data_ok with drop_cnt != 0: decrement drop_cnt; rdata is discarded.
- inst_data_ok with drop_cnt == 0: write rdata into the fill slot, set filled, and advance fill. Fill skips already-filled misaligned slots, so it always targets the oldest unfilled aligned slot.
- out_valid = head slot filled && count != 0 && !flush_i. Pop on out_valid && out_ready.
- flush_i: clear all slots, pointers and count.
  - drop_cnt <= drop_cnt + (old allocated-unfilled aligned slots) − (inst_data_ok this cycle ? 1 : 0).
  - An allocation in the flush cycle is permitted. It lands in slot 0 with the new pc_address. The space check for that allocation uses post-flush count = 0 with the updated drop_cnt.
- drop_cnt is log2(DEPTH)+1 bits wide and never exceeds DEPTH.

## Timing
- Reset values (asynchronous): count=0, all pointers 0, drop_cnt=0, all filled=0. Outputs: out_valid=0, out_pc=0, out_inst=0, out_adel=0, inst_req=0, stall_o=1.
- Accept at cycle N, data_ok at N+k (k≥1): entry filled at N+k edge, out_valid from N+k+1.
- Misaligned allocation at cycle N: out_valid at N+1 if it is the head.
- Sustained throughput: 1 entry/cycle when memory returns every cycle and out_ready=1.
- Same-cycle events:
  - flush beats pop: no pop occurs.
  - flush beats fill: the data_ok counts against the old pending fetches.
  - A pop and an allocation in the same cycle both take effect.
- Full (count + drop_cnt == DEPTH): inst_req=0, stall_o=1, and pc_address is held by the PC.
- Reset mid-operation: all state cleared immediately. The memory side is reset together with this block, so there are no stale responses.

## Configuration
- IFETCH_BYPASS_EN: when defined, an inst_data_ok filling the head slot while count != 0 presents out_valid=1 and out_inst=inst_rdata combinationally in the same cycle. A pop in that cycle retires the entry without it being marked filled. When undefined, out_valid is driven only from registered state, as described above.

## Test plan
- Reset release, pc 0xbfc00000, addr_ok=1, data_ok one cycle later returning 0x24080001 → entry {0xbfc00000, 0x24080001, adel=0}, out_valid exactly 2 cycles after accept.
- out_ready=0, DEPTH=4, memory always ready → 4 entries allocated, then stall_o=1 and inst_req=0. One pop → one new allocation on the following cycle.
- pc_address 0xbfc00002 → no inst_req; entry {0xbfc00002, 0, adel=1} delivered in order behind an earlier pending aligned fetch.
- Two fetches outstanding, flush_i with target 0xbfc00380 accepted the same cycle → drop_cnt=2. The next two data_ok are discarded; the third fills {0xbfc00380, …}.
- Flush coinciding with data_ok and with out_valid && out_ready → no pop, drop_cnt = pending − 1, out_valid=0 that cycle.
- With IFETCH_BYPASS_EN: empty queue, data_ok → out_valid in the same cycle with out_inst=inst_rdata. Without it: out_valid one cycle later.
